// File: rtl/arm_mem_pkg.sv
// Shared memory-subsystem definitions: SRAM bridge state encoding, the
// default data-segment base address and the board SRAM bus widths.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_t;

    localparam logic [31:0] DATA_BASE_DEFAULT = 32'd1024;
    localparam int          SRAM_DATA_W       = 16;
    localparam int          SRAM_ADDR_W       = 18;

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two half-word cycles on the
// 16-bit asynchronous SRAM, stalling the pipeline through `ready` until done.
module sram_controller
    import arm_mem_pkg::*;
#(
    parameter int          ACCESS_CYCLES = 2,
    parameter logic [31:0] DATA_BASE     = DATA_BASE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wrEn,
    input  logic                   rdEn,
    input  logic [31:0]            address,
    input  logic [31:0]            writeData,
    output logic [31:0]            readData,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] sramData,
    output logic [SRAM_ADDR_W-1:0] sramAddress,
    output logic                   sramUB_N,
    output logic                   sramLB_N,
    output logic                   sramCE_N,
    output logic                   sramWE_N,
    output logic                   sramOE_N
);

    localparam int               CNT_W    = $clog2(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    sram_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      readData_q, readData_d;

    logic        [16:0]            idx;
    logic                          in_phase;
    logic                          is_read;
    logic                          last;
    logic                          drive_dq;
    logic        [SRAM_DATA_W-1:0] wr_half;

    // Addresses below the base wrap around the 17-bit word space.
    assign idx      = 17'((address - DATA_BASE) >> 2);
    assign in_phase = (state_q == LOW) || (state_q == HIGH);
    assign is_read  = rdEn & ~wrEn;
    assign last     = (cnt_q == CNT_LAST);
    assign drive_dq = in_phase & wrEn;
    assign wr_half  = (state_q == HIGH) ? writeData[31:16] : writeData[15:0];

    assign sramData    = drive_dq ? wr_half : {SRAM_DATA_W{1'bz}};
    assign sramAddress = {idx, state_q == HIGH};
    // The final count of each write phase holds data with WE_N released.
    assign sramWE_N    = ~(drive_dq & ~last);
    assign sramOE_N    = ~(in_phase & is_read);
    assign sramUB_N    = 1'b0;
    assign sramLB_N    = 1'b0;
    assign sramCE_N    = 1'b0;

    // A request held during reset is not pending, so the pipeline is not frozen.
    assign ready    = ((state_q == IDLE) && (rst || !(rdEn || wrEn))) ||
                      (state_q == DONE);
    assign readData = readData_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        readData_d = readData_q;
        unique case (state_q)
            IDLE: begin
                if (rdEn || wrEn) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end
            end
            LOW: begin
                if (last) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (is_read && in_phase && last) begin
            if (state_q == HIGH) readData_d[31:16] = sramData;
            else                 readData_d[15:0]  = sramData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            readData_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            readData_q <= readData_d;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: two instances (2 and 4 cycles per
// phase), each attached to a behavioural 256Kx16 asynchronous SRAM.
module tb_sram_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: ACCESS_CYCLES = 2
    logic        a_wr = 1'b0, a_rd = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0;
    logic [31:0] a_rdata;
    logic        a_ready;
    wire  [15:0] a_dq;
    logic [17:0] a_sa;
    logic        a_ub, a_lb, a_ce, a_we, a_oe;

    // Instance B: ACCESS_CYCLES = 4
    logic        b_wr = 1'b0, b_rd = 1'b0;
    logic [31:0] b_addr = '0, b_wdata = '0;
    logic [31:0] b_rdata;
    logic        b_ready;
    wire  [15:0] b_dq;
    logic [17:0] b_sa;
    logic        b_ub, b_lb, b_ce, b_we, b_oe;

    sram_controller #(.ACCESS_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .wrEn(a_wr), .rdEn(a_rd), .address(a_addr),
        .writeData(a_wdata), .readData(a_rdata), .ready(a_ready),
        .sramData(a_dq), .sramAddress(a_sa), .sramUB_N(a_ub), .sramLB_N(a_lb),
        .sramCE_N(a_ce), .sramWE_N(a_we), .sramOE_N(a_oe)
    );

    sram_controller #(.ACCESS_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .wrEn(b_wr), .rdEn(b_rd), .address(b_addr),
        .writeData(b_wdata), .readData(b_rdata), .ready(b_ready),
        .sramData(b_dq), .sramAddress(b_sa), .sramUB_N(b_ub), .sramLB_N(b_lb),
        .sramCE_N(b_ce), .sramWE_N(b_we), .sramOE_N(b_oe)
    );

    // Behavioural SRAMs: drive DQ while OE_N is low, store while WE_N is low.
    logic [15:0] mem_a [0:262143];
    logic [15:0] mem_b [0:262143];
    assign a_dq = !a_oe ? mem_a[a_sa] : 16'hzzzz;
    assign b_dq = !b_oe ? mem_b[b_sa] : 16'hzzzz;
    always @(posedge clk) if (a_we === 1'b0) mem_a[a_sa] <= a_dq;
    always @(posedge clk) if (b_we === 1'b0) mem_b[b_sa] <= b_dq;

    // WE_N low-pulse lengths, in cycles.
    int a_run = 0, b_run = 0;
    int a_pulses[$];
    int b_pulses[$];
    always @(posedge clk) begin
        if (a_we === 1'b0) a_run <= a_run + 1;
        else if (a_run != 0) begin a_pulses.push_back(a_run); a_run <= 0; end
    end
    always @(posedge clk) begin
        if (b_we === 1'b0) b_run <= b_run + 1;
        else if (b_run != 0) begin b_pulses.push_back(b_run); b_run <= 0; end
    end

    // Strobe activity with no request outstanding.
    int idle_strobe = 0;
    always @(posedge clk) begin
        if (cyc > 2 && !rst && !a_wr && !a_rd && (a_we !== 1'b1 || a_oe !== 1'b1))
            idle_strobe <= idle_strobe + 1;
        if (cyc > 2 && !rst && !b_wr && !b_rd && (b_we !== 1'b1 || b_oe !== 1'b1))
            idle_strobe <= idle_strobe + 1;
    end

    always @(posedge clk) begin
        if (!rst) assert (!(a_wr && a_rd) && !(b_wr && b_rd))
            else $error("simultaneous load and store request");
    end

    // Word-level reference model of instance A's memory.
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd = '0;

    function automatic int key_of(input logic [31:0] addr);
        longint off;
        off = longint'(addr) - 1024;
        return int'(((off / 4) % 131072 + 131072) % 131072);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr);
        int k;
        k = key_of(addr);
        return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    endfunction

    // Called at a falling edge; returns at the falling edge after DONE.
    task automatic access_a(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                            output int lows, output int start_c, output int done_c,
                            output logic [31:0] rd);
        a_addr = addr; a_wdata = data; a_wr = wr; a_rd = !wr;
        start_c = cyc;
        lows = 0;
        #1;
        while (a_ready !== 1'b1 && lows < 100) begin
            lows++;
            @(negedge clk); #1;
        end
        done_c = cyc;
        rd = a_rdata;
        if (wr) ref_mem[key_of(addr)] = data;
        @(negedge clk);
        a_wr = 1'b0; a_rd = 1'b0;
    endtask

    task automatic test_reset();
        int lows, s, d;
        logic [31:0] rd;
        logic [31:0] wd;
        wd = $urandom;
        a_addr = 32'd2048; a_wdata = wd; a_wr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (a_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready cyc%0d got %b want 1", i, a_ready); end
            n_cmp++;
            if (a_we !== 1'b1 || a_oe !== 1'b1) begin n_bad++; $display("FAIL reset_strobes got WE=%b OE=%b want 1/1", a_we, a_oe); end
        end
        n_cmp++;
        if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_readData got %h/%h want 0", a_rdata, b_rdata); end
        n_cmp++;
        if ({a_ub, a_lb, a_ce, b_ub, b_lb, b_ce} !== 6'b0) begin n_bad++; $display("FAIL tie_offs got %b want 0", {a_ub, a_lb, a_ce, b_ub, b_lb, b_ce}); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (a_ready !== 1'b0) begin n_bad++; $display("FAIL ready_after_release got %b want 0", a_ready); end
        access_a(1'b1, 32'd2048, wd, lows, s, d, rd);
        n_cmp++;
        if (lows !== 5) begin n_bad++; $display("FAIL reset_write_latency got %0d want 5", lows); end
    endtask

    task automatic test_store_load();
        int lows, s, d;
        logic [31:0] rd;
        a_pulses.delete();
        access_a(1'b1, 32'd1024, 32'hDEADBEEF, lows, s, d, rd);
        n_cmp++;
        if (lows !== 5) begin n_bad++; $display("FAIL store_latency got %0d want 5", lows); end
        n_cmp++;
        if (mem_a[0] !== 16'hBEEF || mem_a[1] !== 16'hDEAD) begin n_bad++; $display("FAIL store_halves got %h/%h want BEEF/DEAD", mem_a[0], mem_a[1]); end
        n_cmp++;
        if (rd !== last_rd) begin n_bad++; $display("FAIL store_keeps_readData got %h want %h", rd, last_rd); end
        n_cmp++;
        if (a_pulses.size() !== 2 || a_pulses[0] !== 1 || a_pulses[1] !== 1) begin
            n_bad++; $display("FAIL we_pulses_ac2 got n=%0d want 2 pulses of 1", a_pulses.size());
        end
        access_a(1'b0, 32'd1024, 32'h0, lows, s, d, rd);
        last_rd = rd;
        n_cmp++;
        if (lows !== 5) begin n_bad++; $display("FAIL load_latency got %0d want 5", lows); end
        n_cmp++;
        if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_data got %h want DEADBEEF", rd); end
    endtask

    task automatic test_address_map();
        int lows, s, d;
        logic [31:0] rd;
        logic [31:0] wd;
        access_a(1'b1, 32'd1032, 32'h12345678, lows, s, d, rd);
        n_cmp++;
        if (mem_a[4] !== 16'h5678 || mem_a[5] !== 16'h1234) begin n_bad++; $display("FAIL map_1032 got %h/%h want 5678/1234", mem_a[4], mem_a[5]); end
        wd = $urandom;
        access_a(1'b1, 32'd1020, wd, lows, s, d, rd);
        n_cmp++;
        if (mem_a[18'h3FFFE] !== wd[15:0] || mem_a[18'h3FFFF] !== wd[31:16]) begin
            n_bad++; $display("FAIL map_wrap got %h/%h want %h/%h", mem_a[18'h3FFFE], mem_a[18'h3FFFF], wd[15:0], wd[31:16]);
        end
        access_a(1'b0, 32'd1020, 32'h0, lows, s, d, rd);
        last_rd = rd;
        n_cmp++;
        if (rd !== wd) begin n_bad++; $display("FAIL wrap_readback got %h want %h", rd, wd); end
    endtask

    task automatic test_back_to_back();
        int lows1, lows2, s1, d1, s2, d2;
        logic [31:0] rd;
        access_a(1'b1, 32'd1024, 32'h000000A5, lows1, s1, d1, rd);
        access_a(1'b0, 32'd1024, 32'h0, lows2, s2, d2, rd);
        last_rd = rd;
        n_cmp++;
        if (rd !== 32'h000000A5) begin n_bad++; $display("FAIL b2b_data got %h want 000000A5", rd); end
        n_cmp++;
        if (d2 - s1 + 1 !== 12) begin n_bad++; $display("FAIL b2b_total_cycles got %0d want 12", d2 - s1 + 1); end
    endtask

    task automatic test_random();
        int lows, s, d;
        logic [31:0] rd, addr, wd, exp;
        bit wr;
        for (int i = 0; i < 24; i++) begin
            wr = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 7) == 0) addr = 32'd1024 - 32'(4 * $urandom_range(1, 8));
            else                           addr = 32'd1024 + 32'(4 * $urandom_range(0, 31));
            wd = $urandom;
            exp = wr ? last_rd : ref_read(addr);
            access_a(wr, addr, wd, lows, s, d, rd);
            if (!wr) last_rd = rd;
            n_cmp++;
            if (rd !== exp) begin n_bad++; $display("FAIL rand_readData i=%0d wr=%0d addr=%h got %h want %h", i, wr, addr, rd, exp); end
            n_cmp++;
            if (lows !== 5) begin n_bad++; $display("FAIL rand_latency i=%0d got %0d want 5", i, lows); end
        end
    endtask

    task automatic test_param_sweep();
        int lows;
        logic [31:0] wd, got;
        wd = $urandom;
        b_pulses.delete();
        b_addr = 32'd1032; b_wdata = wd; b_wr = 1'b1; b_rd = 1'b0;
        lows = 0; #1;
        while (b_ready !== 1'b1 && lows < 100) begin lows++; @(negedge clk); #1; end
        @(negedge clk);
        b_wr = 1'b0;
        n_cmp++;
        if (lows !== 9) begin n_bad++; $display("FAIL ac4_write_latency got %0d want 9", lows); end
        n_cmp++;
        if (b_pulses.size() !== 2 || b_pulses[0] !== 3 || b_pulses[1] !== 3) begin
            n_bad++; $display("FAIL ac4_we_pulses got n=%0d want 2 pulses of 3", b_pulses.size());
        end
        n_cmp++;
        if (mem_b[4] !== wd[15:0] || mem_b[5] !== wd[31:16]) begin n_bad++; $display("FAIL ac4_halves got %h/%h want %h/%h", mem_b[4], mem_b[5], wd[15:0], wd[31:16]); end
        b_rd = 1'b1;
        lows = 0; #1;
        while (b_ready !== 1'b1 && lows < 100) begin lows++; @(negedge clk); #1; end
        got = b_rdata;
        @(negedge clk);
        b_rd = 1'b0;
        n_cmp++;
        if (lows !== 9) begin n_bad++; $display("FAIL ac4_read_latency got %0d want 9", lows); end
        n_cmp++;
        if (got !== wd) begin n_bad++; $display("FAIL ac4_read_data got %h want %h", got, wd); end
    endtask

    task automatic test_reset_mid_access();
        int lows, s, d;
        logic [31:0] rd, exp;
        exp = ref_read(32'd1024);
        a_addr = 32'd1024; a_rd = 1'b1; a_wr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (a_oe !== 1'b0 || a_sa !== 18'd1) begin n_bad++; $display("FAIL mid_high_phase got OE=%b addr=%h want 0/00001", a_oe, a_sa); end
        rst = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if (a_rdata !== 32'h0) begin n_bad++; $display("FAIL mid_reset_readData got %h want 0", a_rdata); end
        n_cmp++;
        if (a_ready !== 1'b1 || a_oe !== 1'b1 || a_we !== 1'b1) begin
            n_bad++; $display("FAIL mid_reset_idle got ready=%b OE=%b WE=%b want 1/1/1", a_ready, a_oe, a_we);
        end
        rst = 1'b0; a_rd = 1'b0;
        @(negedge clk);
        access_a(1'b0, 32'd1024, 32'h0, lows, s, d, rd);
        last_rd = rd;
        n_cmp++;
        if (rd !== exp || lows !== 5) begin n_bad++; $display("FAIL post_reset_read got %h/%0d want %h/5", rd, lows, exp); end
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) begin
            mem_a[i] = 16'h0;
            mem_b[i] = 16'h0;
        end
        test_reset();
        test_store_load();
        test_address_map();
        test_back_to_back();
        test_random();
        test_param_sweep();
        test_reset_mid_access();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (idle_strobe !== 0) begin n_bad++; $display("FAIL idle_strobes got %0d want 0", idle_strobe); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Bridges the MEM stage's 32-bit load/store requests to the board's 16-bit asynchronous SRAM. Each access is split into two half-word SRAM cycles (low half, then high half), with a `ready` handshake that freezes the whole pipeline until the access completes. Sits directly downstream of the MEM stage and replaces the raw SRAM pin pass-through at top level.

## Interface
Parameters:
- `ACCESS_CYCLES`, 2: cycles each half-word phase is held on the SRAM bus; legal range 2..15.
- `DATA_BASE`, 1024: byte address that maps to SRAM word 0.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wrEn`  in  1  store request from MEM stage, held stable while `ready`=0.
- `rdEn`  in  1  load request from MEM stage, held stable while `ready`=0.
- `address`  in  32  byte address (ALU result), held stable while `ready`=0.
- `writeData`  in  32  store value, held stable while `ready`=0.
- `readData`  out  32  last completed load value.
- `ready`  out  1  1 = no access pending or access completes this cycle; 0 = freeze pipeline.
- `sramData`  inout  16  SRAM DQ bus.
- `sramAddress`  out  18  SRAM half-word address.
- `sramUB_N`, `sramLB_N`, `sramCE_N`  out  1 each  tied 0.
- `sramWE_N`  out  1  write strobe, active low.
- `sramOE_N`  out  1  output enable, active low.

## Operation
- Word index `idx = (address - DATA_BASE) >> 2`, 32-bit two's-complement subtract, truncated to 17 bits. Addresses below `DATA_BASE` wrap modulo 2^17 words; no error flag.
- Low half at `sramAddress = {idx, 1'b0}`; high half at `{idx, 1'b1}`.
- States: IDLE, LOW, HIGH, DONE. A phase counter counts 0..ACCESS_CYCLES-1 inside LOW and HIGH.
- IDLE: with `rdEn|wrEn` = 1, go to LOW and clear the counter; otherwise stay.
- LOW: when count = ACCESS_CYCLES-1, go to HIGH and clear the counter.
- HIGH: when count = ACCESS_CYCLES-1, go to DONE.
- DONE: always return to IDLE.
- `ready` is combinational:
  - 1 in IDLE with no request.
  - 1 in DONE.
  - 0 otherwise.
- Write, LOW/HIGH phases:
  - `sramData` is driven with `writeData[15:0]` (LOW) or `writeData[31:16]` (HIGH).
  - `sramWE_N` = 0 for all counts except the last count of the phase, which is a data-hold cycle with `WE_N` = 1.
  - `sramOE_N` = 1.
- Read, LOW/HIGH phases:
  - `sramData` is high-Z and `sramOE_N` = 0.
  - On the last-count edge, `sramData` is registered into `readData[15:0]` (LOW) or `readData[31:16]` (HIGH).
- `rdEn` and `wrEn` both 1: treated as a write. The bench flags this with an assertion.
- Outside LOW/HIGH:
  - `sramData` is high-Z.
  - `WE_N` = 1 and `OE_N` = 1.
  - `sramAddress` holds `{idx,0}`.
- `readData` holds its value until the next read's phases overwrite it. Writes never change it.

## Timing
- Reset values:
  - state IDLE, counter 0, `readData` 0.
  - `sramWE_N` 1, `sramOE_N` 1, `sramData` high-Z.
  - `ready` 1 while inputs are idle.
- Latency: with request visible in cycle 0, `ready` is 0 for cycles 0..2·ACCESS_CYCLES and 1 in cycle 2·ACCESS_CYCLES+1. The pipeline advances on that cycle's closing edge. Default: `ready` low 5 cycles, high in the 6th.
- Load data is valid on `readData` in the DONE cycle and after it.
- Back-to-back requests: the new request appears in IDLE one cycle after DONE. It costs the same latency and adds no idle bubble beyond IDLE itself.
- Reset mid-access:
  - returns to IDLE on the next edge.
  - `WE_N` deasserts that edge.
  - a partially written word is left as-is.
  - `readData` is cleared.
- No request means no SRAM strobe activity.

## Structure
- Shared package `arm_mem_pkg` holds:
  - the state enum `sram_state_t` (IDLE/LOW/HIGH/DONE).
  - the `DATA_BASE` default constant.
  - SRAM widths: data 16, address 18.
- No sub-module.
- Phase counter width: `$clog2(ACCESS_CYCLES)`, inline.
- The tri-state driver is a single continuous assign, enabled only in write LOW/HIGH.

## Test plan
The bench uses a behavioural 256K×16 SRAM model.
- Reset: assert `rst` 2 cycles with `wrEn`=1 → `ready`=0 only after release, `readData`=0, `WE_N`=1 throughout reset.
- Store then load: write 0xDEADBEEF to address 1024, then read 1024:
  - SRAM half-word 0 = 0xBEEF, half-word 1 = 0xDEAD.
  - `readData` = 0xDEADBEEF in DONE.
  - `ready` low exactly 5 cycles for each access.
- Address mapping: write 0x12345678 to 1032 → SRAM halves 4/5 = 0x5678/0x1234; address 1020 wraps to halves 0x3FFFE/0x3FFFF.
- Back-to-back: a read of 1024 immediately after a write of 0x0000_00A5 to 1024 returns 0x000000A5; the total is 12 cycles for two accesses.
- Parameter sweep: ACCESS_CYCLES=4 → `ready` low 9 cycles and each `WE_N` pulse low 3 cycles.
- Reset mid-access: assert `rst` during the HIGH phase of a read → next cycle IDLE, `readData`=0; a subsequent read completes normally.
